// File: rtl/pwm_servo_multich.sv
// pwm_servo_multich
//
// N-channel PWM generator sharing one prescaler and one step counter.
// Each channel has a duty value and a mode. In free mode the duty spans the
// whole period. In servo mode the duty maps into a SERVO_MIN..SERVO_MAX step
// window. Writes go into shadow (pending) registers. All channels copy pending
// into active together at the period wrap, so an output never changes its
// threshold part-way through a period.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active HIGH (1 = reset)
//   ena           run enable; 0 freezes the counters and forces outputs low
//   wr_en         write strobe, one cycle per write
//   wr_ch         target channel of the write
//   wr_duty       duty value to write
//   wr_mode       0 = free PWM, 1 = servo
//   wr_ack        one-cycle pulse: write accepted
//   wr_err        one-cycle pulse: write rejected (wr_ch >= CHANNELS)
//   period_start  one-cycle pulse in the first cycle of step 0
//   pwm_out       registered PWM outputs, one bit per channel

module pwm_servo_multich #(
    parameter int CHANNELS  = 3,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 10416,
    parameter int SERVO_MIN = 13,
    parameter int SERVO_MAX = 26
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                ena,
    input  logic                                                wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  wr_ch,
    input  logic [WIDTH-1:0]                                    wr_duty,
    input  logic                                                wr_mode,
    output logic                                                wr_ack,
    output logic                                                wr_err,
    output logic                                                period_start,
    output logic [CHANNELS-1:0]                                 pwm_out
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int Q_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int THR_W  = WIDTH + 1;
    localparam int PROD_W = WIDTH + $clog2(SERVO_MAX) + 1;
    localparam int SPAN   = SERVO_MAX - SERVO_MIN;

    logic [Q_W-1:0]                      q;
    logic [WIDTH-1:0]                    d;
    logic                                tick;
    logic                                boundary;
    logic                                wr_valid;

    logic [CHANNELS-1:0][WIDTH-1:0]      pending_duty;
    logic [CHANNELS-1:0][WIDTH-1:0]      active_duty;
    logic [CHANNELS-1:0]                 pending_mode;
    logic [CHANNELS-1:0]                 active_mode;
    logic [CHANNELS-1:0][THR_W-1:0]      thr;

    assign tick     = ena && (q == Q_W'(PRESCALE - 1));
    assign boundary = tick && (d == {WIDTH{1'b1}});
    // One extra bit so the compare is not constant when CHANNELS is a power of two.
    assign wr_valid = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(CHANNELS));

    // Servo threshold: the product is kept at full width before the shift so
    // the floor is taken on the exact value.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_thr
        logic [PROD_W-1:0] prod;
        assign prod   = PROD_W'(active_duty[i]) * PROD_W'(SPAN);
        assign thr[i] = active_mode[i] ? (THR_W'(SERVO_MIN) + THR_W'(prod >> WIDTH))
                                       : {1'b0, active_duty[i]};
    end

    // Prescaler and step counter; both hold while ena is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q <= '0;
            d <= '0;
        end else if (ena) begin
            if (q == Q_W'(PRESCALE - 1)) begin
                q <= '0;
            end else begin
                q <= q + 1'b1;
            end
            if (tick) begin
                d <= d + 1'b1;
            end
        end
    end

    // Write port and shadow transfer. A write landing in the boundary cycle
    // only reaches pending; active takes the value pending held before it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pending_duty <= '0;
            pending_mode <= '0;
            active_duty  <= '0;
            active_mode  <= '0;
            wr_ack       <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            wr_ack <= wr_valid;
            wr_err <= wr_en && !wr_valid;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_valid && (wr_ch == CH_W'(i))) begin
                    pending_duty[i] <= wr_duty;
                    pending_mode[i] <= wr_mode;
                end
            end
            if (boundary) begin
                active_duty <= pending_duty;
                active_mode <= pending_mode;
            end
        end
    end

    // Outputs compare the current step before it advances, giving one clock
    // of latency after d changes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= ena && ({1'b0, d} < thr[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_servo_multich.sv
module tb_pwm_servo_multich;

    localparam int CH     = 3;
    localparam int W      = 4;
    localparam int PS     = 2;
    localparam int SMIN   = 2;
    localparam int SMAX   = 6;
    localparam int STEPS  = 1 << W;
    localparam int PER    = STEPS * PS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [W-1:0]  wr_duty;
    logic          wr_mode;
    logic          wr_ack;
    logic          wr_err;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    pwm_servo_multich #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .PRESCALE (PS),
        .SERVO_MIN(SMIN),
        .SERVO_MAX(SMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .wr_mode     (wr_mode),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_on    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position in the frame follows from the number of
    // enabled clocks since reset; thresholds from the duty/mode rules.
    function automatic int ref_thr(input bit mode, input int duty);
        if (mode) return SMIN + (duty * (SMAX - SMIN)) / STEPS;
        return duty;
    endfunction

    int unsigned   en_cnt;
    int            m_pduty [CH];
    int            m_aduty [CH];
    bit            m_pmode [CH];
    bit            m_amode [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_ack, exp_err, exp_ps;

    always @(posedge clk) begin
        int  step;
        bit  is_tick, is_wrap;
        if (rst_n) begin
            en_cnt = 0;
            for (int i = 0; i < CH; i++) begin
                m_pduty[i] = 0; m_aduty[i] = 0; m_pmode[i] = 0; m_amode[i] = 0;
            end
            exp_pwm = '0; exp_ack = 0; exp_err = 0; exp_ps = 0;
        end else begin
            step    = int'((en_cnt / PS) % STEPS);
            is_tick = ena && ((en_cnt % PS) == PS - 1);
            is_wrap = is_tick && (step == STEPS - 1);
            for (int i = 0; i < CH; i++)
                exp_pwm[i] = ena && (step < ref_thr(m_amode[i], m_aduty[i]));
            exp_ps = is_wrap;
            if (is_wrap)
                for (int i = 0; i < CH; i++) begin
                    m_aduty[i] = m_pduty[i]; m_amode[i] = m_pmode[i];
                end
            exp_ack = wr_en && (int'(wr_ch) < CH);
            exp_err = wr_en && (int'(wr_ch) >= CH);
            if (exp_ack) begin
                m_pduty[wr_ch] = int'(wr_duty);
                m_pmode[wr_ch] = wr_mode;
            end
            if (ena) en_cnt++;
        end
    end

    always @(negedge clk) begin
        if (sb_on)
            check("scoreboard", {26'd0, pwm_out, wr_ack, wr_err, period_start},
                                {26'd0, exp_pwm, exp_ack, exp_err, exp_ps});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 200);
        check("period_start_seen", {31'd0, period_start}, 32'd1);
    endtask

    task automatic cycles_to_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 200);
    endtask

    // Counts high samples of one channel over one frame, starting at the
    // period_start cycle the caller is sitting on.
    task automatic count_high(input int ch, output int n);
        n = 0;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            n += int'(pwm_out[ch]);
        end
    endtask

    task automatic do_write(input int ch, input int duty, input bit mode);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = W'(duty);
        wr_mode = mode;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    typedef struct {
        int ch;
        int duty;
        bit mode;
        int exp_hi;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n, hi, len;

        vecs[0] = '{0,  4, 1'b0,  8};
        vecs[1] = '{1,  0, 1'b1,  4};
        vecs[2] = '{1,  8, 1'b1,  8};
        vecs[3] = '{1, 15, 1'b1, 10};
        vecs[4] = '{2, 15, 1'b0, 30};
        vecs[5] = '{0,  0, 1'b0,  0};
        vecs[6] = '{2,  1, 1'b1,  4};
        vecs[7] = '{0, 12, 1'b1, 10};
        vecs[8] = '{1,  3, 1'b0,  6};

        rst_n = 1'b1; ena = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_mode = 1'b0;

        // Reset and idle
        @(negedge clk);
        sb_on = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {28'd0, pwm_out, wr_ack}, 32'd0);
        check("reset_flags", {30'd0, wr_err, period_start}, 32'd0);
        rst_n = 1'b0;
        ena   = 1'b1;
        cycles_to_ps(n);
        check("first_period_start", n, PER);
        cycles_to_ps(n);
        check("period_interval", n, PER);

        // Write landing exactly in the boundary cycle
        repeat (PER - 1) @(negedge clk);
        do_write(2, 10, 1'b0);
        check("collision_ps", {31'd0, period_start}, 32'd1);
        check("collision_ack", {31'd0, wr_ack}, 32'd1);
        count_high(2, hi);
        check("collision_old_value", hi, 0);
        wait_ps();
        count_high(2, hi);
        check("collision_new_value", hi, 20);

        // Table of single-channel writes
        for (int v = 0; v < 9; v++) begin
            wait_ps();
            do_write(vecs[v].ch, vecs[v].duty, vecs[v].mode);
            check("vec_ack", {31'd0, wr_ack}, 32'd1);
            wait_ps();
            count_high(vecs[v].ch, hi);
            check($sformatf("vec%0d_high", v), hi, vecs[v].exp_hi);
        end

        // Invalid channel
        @(negedge clk);
        do_write(3, 5, 1'b0);
        check("invalid_err", {30'd0, wr_err, wr_ack}, 32'd2);

        // Enable gating on a running channel
        do_write(0, 4, 1'b0);
        wait_ps();
        wait_ps();
        hi = int'(pwm_out[0]);
        len = 0;
        repeat (3) begin @(negedge clk); len++; hi += int'(pwm_out[0]); end
        ena = 1'b0;
        @(negedge clk); len++; hi += int'(pwm_out[0]);
        check("ena_off_outputs", {29'd0, pwm_out}, 32'd0);
        repeat (9) begin @(negedge clk); len++; hi += int'(pwm_out[0]); end
        ena = 1'b1;
        do begin
            @(negedge clk);
            len++;
            if (!period_start) hi += int'(pwm_out[0]);
        end while (!period_start && len < 200);
        check("ena_gap_period_len", len, PER + 10);
        check("ena_gap_high_total", hi, 8);

        // Reset in the middle of a period
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out", {29'd0, pwm_out}, 32'd0);
        rst_n = 1'b0;
        cycles_to_ps(n);
        check("midreset_restart", n, PER);
        count_high(0, hi);
        check("midreset_ch0_cleared", hi, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 499) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_duty = W'($urandom);
            wr_mode = 1'($urandom);
            if ($urandom_range(0, 63) == 0) ena = ~ena;
        end
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; ena = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_servo_multich.md
Name: pwm_servo_multich

Overview:
- Parametrised N-channel PWM generator with a shared prescaler and a shared step counter.
- Each channel has its own duty value and its own mode: free PWM (duty maps to the full period) or servo (duty maps to a SERVO_MIN..SERVO_MAX step window, nominally 1–2 ms of a 20 ms frame).
- Duty and mode are written through a simple write port into per-channel shadow registers. They take effect only at a period boundary, so outputs never glitch.
- Sits between the TinyTapeout user inputs and the motor/LED/servo output pins.

Parameters:
- CHANNELS, 3, number of PWM outputs (1..8).
- WIDTH, 8, duty and step-counter width; one period = 2^WIDTH steps.
- PRESCALE, 10416, clk cycles per step (>=1).
- SERVO_MIN, 13, servo-mode threshold (in steps) for duty=0.
- SERVO_MAX, 26, servo-mode upper bound (in steps); must be > SERVO_MIN and <= 2^WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on rising clk).
- ena  in  1  run enable.
- wr_en  in  1  write strobe, one cycle per write.
- wr_ch  in  max(1,$clog2(CHANNELS))  target channel.
- wr_duty  in  WIDTH  duty value.
- wr_mode  in  1  0 = free PWM, 1 = servo.
- wr_ack  out  1  one-cycle pulse, write accepted.
- wr_err  out  1  one-cycle pulse, write rejected (wr_ch >= CHANNELS).
- period_start  out  1  one-cycle pulse at each period wrap.
- pwm_out  out  CHANNELS  registered PWM outputs.

Behaviour:
- Reset (rst_n=1 at clk edge):
  - Prescaler q=0 and step counter d=0.
  - All pending and active duty=0, all modes=0.
  - pwm_out=0, wr_ack=0, wr_err=0, period_start=0.
  - Reset mid-period aborts the period immediately. Pending writes are lost.
- Prescaler:
  - With ena=1, q counts 0..PRESCALE-1, then wraps to 0.
  - tick = ena && (q==PRESCALE-1).
  - PRESCALE=1 gives tick=ena on every cycle.
- Step counter:
  - On tick, d increments modulo 2^WIDTH (2^WIDTH-1 -> 0).
  - boundary = tick && (d==2^WIDTH-1).
- period_start is registered and equals boundary delayed one cycle, i.e. it is high in the first cycle of d=0.
- ena=0:
  - q and d hold.
  - pwm_out is forced to 0 on the next edge.
  - No tick, no boundary.
  - Writes are still accepted.
  - When ena returns, counting resumes from the held q and d.
- Write port:
  - wr_en with a valid wr_ch loads pending_duty[wr_ch]=wr_duty and pending_mode[wr_ch]=wr_mode.
  - wr_ack=1 on the next cycle.
  - Invalid wr_ch: no state change, wr_err=1 on the next cycle.
  - Back-to-back writes are allowed every cycle; the last write to a channel before a boundary wins.
- Shadow transfer:
  - On boundary, active_{duty,mode}[i] <= pending_{duty,mode}[i] for all channels simultaneously.
  - A write in the same cycle as boundary updates pending only. The active registers take the pre-write pending value, so the new value applies one period later.
- Threshold per channel, combinational from active registers:
  - Free mode: thr = active_duty (WIDTH+1 bits).
  - Servo mode: thr = SERVO_MIN + floor(active_duty*(SERVO_MAX-SERVO_MIN) / 2^WIDTH).
  - The servo product is computed at full width (WIDTH + $clog2(SERVO_MAX)+1 bits); no truncation before the shift.
- Output:
  - pwm_out[i] <= ena && (d < thr_i), registered, so output latency is 1 clk after d changes.
  - Free mode: duty=0 gives constant 0. duty=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH steps (never 100%).
  - Servo mode: duty=0 gives SERVO_MIN steps high per period. duty=2^WIDTH-1 gives just under SERVO_MAX steps.
- Channels are independent. A mode change only takes effect at a boundary, like a duty change.

Test Plan:
- Reset/idle: WIDTH=4, PRESCALE=2, CHANNELS=3, SERVO_MIN=2, SERVO_MAX=6; hold rst_n=1 for 3 cycles, then ena=1 with no writes -> pwm_out=3'b000 for 2 full periods (64 clks), period_start every 32 clks, first pulse 32 clks after ena.
- Free duty and shadow timing: same parameters; write ch0 duty=4 mode=0 mid-period -> wr_ack high 1 clk after wr_en; pwm_out[0] stays 0 until the next period_start, then is high for 8 clks of every 32.
- Servo mapping: same parameters; ch1 duty=0 mode=1 -> 4 clks high per 32; duty=8 -> thr=2+floor(8*4/16)=4 -> 8 clks high; duty=15 -> thr=5 -> 10 clks high.
- Boundary collision: issue the ch2 duty=10 write exactly in the boundary cycle -> next period uses the old value (0), the following period is high for 20 clks; wr_ack still pulses.
- Invalid channel and ena gating: write wr_ch=3 -> wr_err pulse, no wr_ack, no output change. Drop ena mid-period -> all outputs 0 next clk, d frozen. Raise ena -> the period completes with the remaining steps (total high time unchanged).
- Reset mid-operation: with ch0 active duty=4, assert rst_n for 1 clk at d=2 -> pwm_out=0 next clk, d=q=0, ch0 stays 0 after release until rewritten.
